clk_div_scheduler: RTL

Programmable clock-enable scheduler for the lab clock divider bank. It holds one divide ratio per channel and emits a one-cycle enable strobe per channel every DIV cycles of clk_in. New ratios arrive over a valid/ready config port. A ratio change is applied only at the channel's period boundary, so no short or long period is ever produced. A global sync input phase-aligns all channels.

---
 rtl/clk_div_scheduler.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/clk_div_scheduler.sv
// -----------------------------------------------------------------------------
// clk_div_scheduler
//
// Programmable clock-enable scheduler for the lab clock divider bank. Each
// channel holds a divide ratio and emits a registered one-cycle strobe every
// DIV cycles of clk_in. A new ratio is written through a valid/ready config
// port and takes effect only on the channel's period boundary, so a period is
// never cut short or stretched. A one-cycle sync input restarts every enabled
// channel counter together.
//
// Optional feature macro: CLK_DIV_SCHED_TOGGLE_EN
//   defined   : clk_div_out[ch] is a 50% square wave of period 2*div
//   undefined : clk_div_out is tied to zero and no toggle flops exist
//
// Ports:
//   clk_in      in   system clock, all state on posedge
//   rst_n       in   asynchronous active-low reset
//   cfg_valid   in   config request valid
//   cfg_ready   out  config port ready, high only in IDLE
//   cfg_ch      in   target channel index
//   cfg_div     in   new ratio (0 disables the channel)
//   cfg_done    out  one-cycle pulse when the pending config is applied/rejected
//   cfg_err     out  one-cycle pulse with cfg_done for an out-of-range channel
//   sync        in   one-cycle request to restart all channel counters
//   busy        out  high while a config is pending (FSM state is WAIT)
//   strobe      out  per-channel one-cycle enable pulses, registered
//   clk_div_out out  per-channel square wave (optional feature)
//
// Handshake: a config request transfers on a clk_in edge where cfg_valid and
// cfg_ready are both high. cfg_ready depends only on the FSM state, and the
// requester holds cfg_valid and its payload until that edge; cfg_valid seen
// while cfg_ready is low is ignored. busy is the FSM state made visible.
// -----------------------------------------------------------------------------
module clk_div_scheduler #(
    parameter int NCH   = 4,
    parameter int DIV_W = 8,
    parameter int CH_W  = 3
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_done,
    output logic             cfg_err,
    input  logic             sync,
    output logic             busy,
    output logic [NCH-1:0]   strobe,
    output logic [NCH-1:0]   clk_div_out
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [CH_W:0] NCH_L = NCH[CH_W:0];

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] div_q [NCH];
    logic [DIV_W-1:0] cnt_q [NCH];
    logic [CH_W-1:0]  pend_ch;
    logic [DIV_W-1:0] pend_div;

    logic [NCH-1:0]   en;        // channel has a non-zero ratio
    logic [NCH-1:0]   at_wrap;   // counter sits on its last count of the period
    logic [NCH-1:0]   tgt;       // one-hot decode of the pending channel
    logic [NCH-1:0]   load;      // channel takes the pending ratio this edge
    logic             tgt_valid;
    logic             tgt_disabled;
    logic             tgt_boundary;
    logic             apply;

    // Channel status and pending-target decode. The target is decoded by
    // comparison rather than by indexing so an out-of-range pend_ch never
    // addresses a non-existent channel.
    always_comb begin
        en      = '0;
        at_wrap = '0;
        tgt     = '0;
        for (int i = 0; i < NCH; i++) begin
            en[i]      = (div_q[i] != '0);
            at_wrap[i] = en[i] && (cnt_q[i] == div_q[i] - DIV_W'(1));
            tgt[i]     = (pend_ch == CH_W'(i));
        end
    end

    assign tgt_valid    = ({1'b0, pend_ch} < NCH_L);
    assign tgt_disabled = |(tgt & ~en);
    assign tgt_boundary = |(tgt & at_wrap);

    // A pending config lands at the first edge where it cannot disturb a
    // running period: bad target, idle channel, period boundary, or a sync
    // that restarts every counter anyway.
    assign apply = (state == WAIT) &&
                   (!tgt_valid || tgt_disabled || tgt_boundary || sync);
    assign load  = (apply && tgt_valid) ? tgt : '0;

    // FSM state register
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and outputs
    always_comb begin
        state_nxt = state;
        cfg_ready = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (apply) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pending request capture and completion pulses
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            pend_ch  <= '0;
            pend_div <= '0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            if ((state == IDLE) && cfg_valid) begin
                pend_ch  <= cfg_ch;
                pend_div <= cfg_div;
            end
            cfg_done <= apply;
            cfg_err  <= apply && !tgt_valid;
        end
    end

    // Channel ratio, counter and strobe. The strobe is computed from the
    // pre-edge ratio, so the old period's boundary strobe still fires on the
    // edge that loads a new ratio; sync suppresses strobes on its edge.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                div_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            strobe <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                strobe[i] <= at_wrap[i] && !sync;
                if (load[i]) begin
                    div_q[i] <= pend_div;
                    cnt_q[i] <= '0;
                end else if (sync || at_wrap[i] || !en[i]) begin
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + DIV_W'(1);
                end
            end
        end
    end

`ifdef CLK_DIV_SCHED_TOGGLE_EN
    logic [NCH-1:0] tog_q;

    // Toggles alongside each strobe; a channel switched off or a sync parks
    // the wave low so it restarts in phase with the counters.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            tog_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (sync || (load[i] && (pend_div == '0))) begin
                    tog_q[i] <= 1'b0;
                end else if (at_wrap[i]) begin
                    tog_q[i] <= ~tog_q[i];
                end
            end
        end
    end

    assign clk_div_out = tog_q;
`else
    assign clk_div_out = '0;
`endif

endmodule
